// File: rtl/set_bank.sv
// Key-protected slow-device settings bank.
// New settings stay tentative until confirmed and fall back on timeout.
module set_bank #(
   parameter int NCH = 7,
   parameter int TOW = 4,
   parameter logic [NCH-1:0] DEF_SLOW = {NCH{1'b1}},
   parameter int DEF_TO = 3,
   parameter int KEY = 'h5A,
   parameter int CW = 16,
   parameter logic [CW-1:0] CONF_LEN = 16'hFFFF,
   localparam int DW = TOW + NCH + 1,
   localparam int AW = DW + 2
) (
   input  logic           CLK,
   input  logic           nPOR,
   input  logic           BACT,
   input  logic           SetCSWR,
   input  logic [AW:1]    A,
   output logic [NCH-1:0] Slow,
   output logic           SlowClockGate,
   output logic [TOW-1:0] SlowTimeout,
   output logic           Unlocked,
   output logic           Pending,
   output logic           Reverted
);

   localparam logic [1:0] LOCK = 2'd0;
   localparam logic [1:0] UNLK = 2'd1;
   localparam logic [1:0] PEND = 2'd2;

   localparam logic [1:0] OP_WR   = 2'b00;
   localparam logic [1:0] OP_CONF = 2'b01;
   localparam logic [1:0] OP_REV  = 2'b10;
   localparam logic [1:0] OP_KEY  = 2'b11;

   localparam int KW = (DW < 8) ? DW : 8;
   localparam logic [KW-1:0] KEYL = KW'(KEY);
   localparam logic [DW-1:0] DEF_ACT =
      {TOW'(DEF_TO), DEF_SLOW, 1'b0};

   logic          wrR;
   logic          wrRd;
   logic [AW:1]   ar;
   logic [1:0]    st;
   logic [CW-1:0] cnt;
   logic [DW-1:0] act;
   logic [DW-1:0] bak;
   logic          rev;

   logic          cmd;
   logic [1:0]    op;
   logic [DW-1:0] data;
   logic          keyOk;

   // One command per bus cycle: only the rising edge of the strobe counts.
   assign cmd   = wrR && !wrRd;
   assign op    = ar[AW:DW+1];
   assign data  = ar[DW:1];
   assign keyOk = (data[KW-1:0] == KEYL);

   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         wrR  <= 1'b0;
         wrRd <= 1'b0;
         ar   <= '0;
         st   <= LOCK;
         cnt  <= '0;
         act  <= DEF_ACT;
         bak  <= DEF_ACT;
         rev  <= 1'b0;
      end else begin
         wrR  <= BACT && SetCSWR;
         wrRd <= wrR;
         ar   <= A;
         rev  <= 1'b0;
         unique case (st)
            LOCK: begin
               cnt <= '0;
               if (cmd && op == OP_KEY && keyOk) begin
                  st  <= UNLK;
                  cnt <= CONF_LEN;
               end
            end
            UNLK: begin
               if (cmd) begin
                  unique case (op)
                     OP_WR: begin
                        bak <= act;
                        act <= data;
                        cnt <= CONF_LEN;
                        st  <= PEND;
                     end
                     OP_KEY: cnt <= CONF_LEN;
                     default: begin
                        st  <= LOCK;
                        cnt <= '0;
                     end
                  endcase
               end else if (cnt == '0) begin
                  st <= LOCK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PEND: begin
               // A key stroke here is not a command; the timer keeps running.
               if (cmd && op != OP_KEY) begin
                  unique case (op)
                     OP_WR: begin
                        act <= data;
                        cnt <= CONF_LEN;
                     end
                     OP_REV: begin
                        act <= bak;
                        st  <= LOCK;
                        cnt <= '0;
                     end
                     default: begin
                        st  <= LOCK;
                        cnt <= '0;
                     end
                  endcase
               end else if (cnt == '0) begin
                  act <= bak;
                  rev <= 1'b1;
                  st  <= LOCK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               st  <= LOCK;
               cnt <= '0;
            end
         endcase
      end
   end

   assign Slow          = act[NCH:1];
   assign SlowClockGate = act[0];
   assign SlowTimeout   = act[DW-1:NCH+1];
   assign Unlocked      = (st == UNLK);
   assign Pending       = (st == PEND);
   assign Reverted      = rev;

endmodule

// File: tb/tb_set_bank.sv
// Directed and random bench for set_bank.
// Expectations come from a deadline-based model of the settings rules.
module tb_set_bank;

   localparam int L = 20;

   logic        CLK;
   logic        nPOR;
   logic        BACT;
   logic        SetCSWR;
   logic [14:1] A;
   logic [6:0]  Slow;
   logic        SlowClockGate;
   logic [3:0]  SlowTimeout;
   logic        Unlocked;
   logic        Pending;
   logic        Reverted;

   set_bank #(.CONF_LEN(16'd20)) dut (
      .CLK(CLK),
      .nPOR(nPOR),
      .BACT(BACT),
      .SetCSWR(SetCSWR),
      .A(A),
      .Slow(Slow),
      .SlowClockGate(SlowClockGate),
      .SlowTimeout(SlowTimeout),
      .Unlocked(Unlocked),
      .Pending(Pending),
      .Reverted(Reverted)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Model: state 0=locked 1=unlocked 2=pending, plus the edge at which
   // the confirm window runs out and the edge carrying a revert pulse.
   int          mSt;
   logic [11:0] mAct;
   logic [11:0] mBak;
   int          mDead;
   int          mRevEdge;

   localparam logic [11:0] DEFV = {4'd3, 7'h7F, 1'b0};

   task automatic modelReset();
      mSt      = 0;
      mAct     = DEFV;
      mBak     = DEFV;
      mDead    = 0;
      mRevEdge = -1;
   endtask

   task automatic modelSync(input int cur);
      if (mSt != 0 && mDead <= cur) begin
         if (mSt == 2) begin
            mAct     = mBak;
            mRevEdge = mDead;
         end
         mSt = 0;
      end
   endtask

   task automatic modelCmd(input int e, input logic [1:0] op,
                           input logic [11:0] d);
      modelSync(e - 1);
      case (mSt)
         0: if (op == 2'b11 && d[7:0] == 8'h5A) begin
            mSt   = 1;
            mDead = e + L + 1;
         end
         1: case (op)
            2'b00: begin
               mBak  = mAct;
               mAct  = d;
               mSt   = 2;
               mDead = e + L + 1;
            end
            2'b11: mDead = e + L + 1;
            default: mSt = 0;
         endcase
         default: case (op)
            2'b00: begin
               mAct  = d;
               mDead = e + L + 1;
            end
            2'b01: mSt = 0;
            2'b10: begin
               mAct = mBak;
               mSt  = 0;
            end
            default: ;
         endcase
      endcase
   endtask

   task automatic checkAll(input string tag);
      logic [11:0] obsAct;
      logic [1:0]  expSt;
      logic        expRev;
      modelSync(cyc);
      obsAct = {SlowTimeout, Slow, SlowClockGate};
      expSt  = {mSt == 1, mSt == 2};
      expRev = (cyc == mRevEdge);
      checks++;
      assert (obsAct === mAct) else begin
         failures++;
         $error("FAIL %s setting cyc=%0d obs=%h exp=%h",
                tag, cyc, obsAct, mAct);
      end
      checks++;
      assert ({Unlocked, Pending} === expSt) else begin
         failures++;
         $error("FAIL %s state cyc=%0d obs=%b exp=%b",
                tag, cyc, {Unlocked, Pending}, expSt);
      end
      checks++;
      assert (Reverted === expRev) else begin
         failures++;
         $error("FAIL %s reverted cyc=%0d obs=%b exp=%b",
                tag, cyc, Reverted, expRev);
      end
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) begin
         @(negedge CLK);
         checkAll(tag);
      end
   endtask

   task automatic stroke(input logic [1:0] op, input logic [11:0] d,
                         input int n, input string tag);
      int k;
      BACT    = 1'b1;
      SetCSWR = 1'b1;
      A       = {op, d};
      @(negedge CLK);
      k = cyc;
      modelCmd(k + 1, op, d);
      repeat (n - 1) @(negedge CLK);
      BACT    = 1'b0;
      SetCSWR = 1'b0;
      @(negedge CLK);
      checkAll(tag);
   endtask

   task automatic doReset(input string tag);
      nPOR    = 1'b0;
      BACT    = 1'b0;
      SetCSWR = 1'b0;
      repeat (2) @(negedge CLK);
      nPOR = 1'b1;
      modelReset();
      checkAll(tag);
   endtask

   localparam logic [1:0] WR = 2'b00;
   localparam logic [1:0] CF = 2'b01;
   localparam logic [1:0] RV = 2'b10;
   localparam logic [1:0] KY = 2'b11;

   initial begin
      logic [11:0] d;
      logic [1:0]  op;
      int          guard;
      nPOR    = 1'b0;
      BACT    = 1'b0;
      SetCSWR = 1'b0;
      A       = '0;
      modelReset();

      doReset("t1_reset");
      idle(2, "t1_idle");

      stroke(WR, 12'h000, 1, "t2_locked_wr");
      stroke(KY, 12'h05B, 1, "t2_bad_key");
      idle(3, "t2_idle");

      stroke(KY, 12'h05A, 1, "t3_key");
      stroke(WR, {4'd8, 7'd0, 1'b1}, 1, "t3_write");
      stroke(CF, 12'h000, 1, "t3_confirm");
      idle(L + 5, "t3_persist");

      stroke(KY, 12'hF5A, 2, "t4_key");
      stroke(WR, 12'hA55, 1, "t4_write");
      idle(L + 5, "t4_expiry");

      stroke(KY, 12'h05A, 1, "t5_key");
      stroke(WR, 12'h123, 10, "t5_long");
      idle(L + 2, "t5_long_expiry");
      stroke(KY, 12'h05A, 1, "t5_key2");
      stroke(WR, 12'h456, 10, "t5_wr1");
      stroke(WR, 12'h789, 1, "t5_wr2");
      stroke(RV, 12'h000, 1, "t5_revert");
      idle(3, "t5_idle");

      stroke(KY, 12'h05A, 1, "t6_key");
      stroke(WR, 12'hBCD, 1, "t6_write");
      guard = 0;
      while (cyc < mDead - 2 && guard < 100) begin
         idle(1, "t6_wait");
         guard++;
      end
      stroke(CF, 12'h000, 1, "t6_race_confirm");
      idle(L + 3, "t6_after_race");

      stroke(KY, 12'h05A, 1, "t6_key2");
      stroke(WR, 12'h0F0, 1, "t6_write2");
      idle(3, "t6_pend");
      doReset("t6_reset_pend");
      idle(3, "t6_post_reset");

      for (int i = 0; i < 80; i++) begin
         op = 2'($urandom_range(0, 3));
         d  = 12'($urandom);
         if (op == KY && $urandom_range(0, 3) != 0) d[7:0] = 8'h5A;
         stroke(op, d, $urandom_range(1, 3), "rnd_cmd");
         idle($urandom_range(0, 24), "rnd_idle");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
